fifo_ctrl: RTL and testbench

Pointer/handshake controller that turns the 16x8 synchronous block RAM into a first-word-fall-through FIFO. It sits directly upstream of the RAM: it drives the RAM's write and read ports and exposes valid/ready push and pop interfaces to the rest of the icestick design. The RAM's registered read data is the FIFO head, so the controller stores no payload itself.

---
 rtl/fifo_ctrl_pkg.sv | 9 +
 rtl/fifo_ctrl_wrap_ptr.sv | 24 ++
 rtl/fifo_ctrl.sv | 109 ++++++++++
 tb/tb_fifo_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared sizing for the FWFT FIFO controller around the 16x8 block RAM.
package fifo_ctrl_pkg;
    localparam int DEPTH_LOG2 = 4;
    localparam int DATA_W     = 8;
    localparam int DEPTH      = 2**DEPTH_LOG2;
    localparam int PTR_W      = DEPTH_LOG2 + 1;

    typedef logic [PTR_W-1:0] ptr_t;
endpackage

// File: rtl/fifo_ctrl_wrap_ptr.sv
// Wrapping pointer: W-bit counter with async active-low clear and increment enable.
import fifo_ctrl_pkg::*;

module wrap_ptr #(
    parameter int W = PTR_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    // Counter register; wraps naturally at 2^W so the MSB acts as the lap bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= {W{1'b0}};
        end else if (inc) begin
            ptr <= ptr + {{(W-1){1'b0}}, 1'b1};
        end else begin
            ptr <= ptr;
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// First-word-fall-through FIFO controller driving an external synchronous RAM.
// Optional sticky overflow/underflow flags are built when FIFO_CTRL_ERR_EN is defined.
import fifo_ctrl_pkg::*;

module fifo_ctrl #(
    parameter int DEPTH_LOG2 = fifo_ctrl_pkg::DEPTH_LOG2,
    parameter int DATA_W     = fifo_ctrl_pkg::DATA_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_valid,
    input  logic [DATA_W-1:0]     push_data,
    output logic                  push_ready,
    output logic                  pop_valid,
    output logic [DATA_W-1:0]     pop_data,
    input  logic                  pop_ready,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  mem_w_en,
    output logic [DEPTH_LOG2-1:0] mem_w_addr,
    output logic [DATA_W-1:0]     mem_w_data,
    output logic                  mem_r_en,
    output logic [DEPTH_LOG2-1:0] mem_r_addr,
    input  logic [DATA_W-1:0]     mem_r_data
`ifdef FIFO_CTRL_ERR_EN
    ,
    output logic                  ovf_err,
    output logic                  udf_err
`endif
);

    localparam int PW = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0] FULL_OCC = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [PW-1:0] wr_ptr_s;
    logic [PW-1:0] rd_ptr_s;
    logic [PW-1:0] occ_s;
    logic          full_s;
    logic          empty_s;
    logic          push_fire_s;
    logic          pop_fire_s;
    logic          fetch_s;
    logic          head_valid_r;

    wrap_ptr #(.W(PW)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (push_fire_s),
        .ptr   (wr_ptr_s)
    );

    wrap_ptr #(.W(PW)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (fetch_s),
        .ptr   (rd_ptr_s)
    );

    // Handshake and fetch decode; occ only counts words not yet moved into the RAM output register.
    always_comb begin
        occ_s       = wr_ptr_s - rd_ptr_s;
        full_s      = (occ_s == FULL_OCC);
        empty_s     = (occ_s == {PW{1'b0}});
        push_ready  = rst_n & ~full_s;
        push_fire_s = push_valid & push_ready;
        pop_valid   = head_valid_r;
        pop_fire_s  = head_valid_r & pop_ready;
        fetch_s     = ~empty_s & (~head_valid_r | pop_ready);
        count       = occ_s + {{(PW-1){1'b0}}, head_valid_r};
        mem_w_en    = push_fire_s;
        mem_w_addr  = wr_ptr_s[DEPTH_LOG2-1:0];
        mem_w_data  = push_data;
        mem_r_en    = fetch_s;
        mem_r_addr  = rd_ptr_s[DEPTH_LOG2-1:0];
        pop_data    = mem_r_data;
    end

    // Head-valid flag tracks whether the RAM read register holds an unpopped word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_valid_r <= 1'b0;
        end else if (fetch_s) begin
            head_valid_r <= 1'b1;
        end else if (pop_fire_s) begin
            head_valid_r <= 1'b0;
        end else begin
            head_valid_r <= head_valid_r;
        end
    end

`ifdef FIFO_CTRL_ERR_EN
    // Sticky protocol-violation flags, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else begin
            if (push_valid & full_s) begin
                ovf_err <= 1'b1;
            end
            if (pop_ready & ~head_valid_r & empty_s) begin
                udf_err <= 1'b1;
            end
        end
    end
`else
    // Without error tracking, the ready/valid gating alone keeps the pointers consistent.
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl with a behavioural 16x8 synchronous RAM attached.
module tb_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       push_valid = 1'b0;
    logic [7:0] push_data = 8'h00;
    logic       push_ready;
    logic       pop_valid;
    logic [7:0] pop_data;
    logic       pop_ready = 1'b0;
    logic [4:0] count;
    logic       mem_w_en;
    logic [3:0] mem_w_addr;
    logic [7:0] mem_w_data;
    logic       mem_r_en;
    logic [3:0] mem_r_addr;
    logic [7:0] mem_r_data;
`ifdef FIFO_CTRL_ERR_EN
    logic       ovf_err;
    logic       udf_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] ram [16];

    fifo_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (push_valid),
        .push_data  (push_data),
        .push_ready (push_ready),
        .pop_valid  (pop_valid),
        .pop_data   (pop_data),
        .pop_ready  (pop_ready),
        .count      (count),
        .mem_w_en   (mem_w_en),
        .mem_w_addr (mem_w_addr),
        .mem_w_data (mem_w_data),
        .mem_r_en   (mem_r_en),
        .mem_r_addr (mem_r_addr),
        .mem_r_data (mem_r_data)
`ifdef FIFO_CTRL_ERR_EN
        ,
        .ovf_err    (ovf_err),
        .udf_err    (udf_err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_w_en) ram[mem_w_addr] <= mem_w_data;
        if (mem_r_en) mem_r_data <= ram[mem_r_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        push_valid = 1'b1;
        push_data  = 8'h11;
        pop_ready  = 1'b1;
        @(negedge clk);
        n_tests++; if (push_ready !== 1'b0) begin n_fail++; $display("FAIL reset_push_ready got %0b want 0", push_ready); end
        n_tests++; if (pop_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pop_valid got %0b want 0", pop_valid); end
        n_tests++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_tests++; if (mem_w_en !== 1'b0 || mem_r_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en got w=%0b r=%0b want 0 0", mem_w_en, mem_r_en); end
        n_tests++; if (mem_w_addr !== 4'd0 || mem_r_addr !== 4'd0) begin n_fail++; $display("FAIL reset_addr got w=%0d r=%0d want 0 0", mem_w_addr, mem_r_addr); end
`ifdef FIFO_CTRL_ERR_EN
        n_tests++; if (ovf_err !== 1'b0 || udf_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %0b %0b want 0 0", ovf_err, udf_err); end
`endif
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        rst_n      = 1'b1;
        @(negedge clk);
        n_tests++; if (push_ready !== 1'b1) begin n_fail++; $display("FAIL release_push_ready got %0b want 1", push_ready); end
    endtask

    task automatic test_single();
        tick();
        push_valid = 1'b1;
        push_data  = 8'hA5;
        @(negedge clk);
        n_tests++; if (mem_w_en !== 1'b1 || mem_w_addr !== 4'd0 || mem_w_data !== 8'hA5) begin n_fail++; $display("FAIL single_write got en=%0b a=%0d d=%h want 1 0 a5", mem_w_en, mem_w_addr, mem_w_data); end
        tick();
        push_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (mem_r_en !== 1'b1 || mem_r_addr !== 4'd0 || pop_valid !== 1'b0) begin n_fail++; $display("FAIL single_fetch got ren=%0b a=%0d pv=%0b want 1 0 0", mem_r_en, mem_r_addr, pop_valid); end
        tick();
        @(negedge clk);
        n_tests++; if (pop_valid !== 1'b1 || pop_data !== 8'hA5 || count !== 5'd1) begin n_fail++; $display("FAIL single_head got pv=%0b d=%h cnt=%0d want 1 a5 1", pop_valid, pop_data, count); end
        tick();
        pop_ready = 1'b1;
        @(negedge clk);
        tick();
        pop_ready = 1'b0;
        @(negedge clk);
        n_tests++; if (pop_valid !== 1'b0 || count !== 5'd0) begin n_fail++; $display("FAIL single_drain got pv=%0b cnt=%0d want 0 0", pop_valid, count); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 17; i++) begin
            tick();
            push_valid = 1'b1;
            push_data  = 8'(i);
            @(negedge clk);
            n_tests++; if (push_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready_%0d got %0b want 1", i, push_ready); end
        end
        tick();
        push_data = 8'h99;
        @(negedge clk);
        n_tests++; if (count !== 5'd17 || push_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full got cnt=%0d rdy=%0b want 17 0", count, push_ready); end
        n_tests++; if (mem_w_en !== 1'b0) begin n_fail++; $display("FAIL fill_refuse got wen=%0b want 0", mem_w_en); end
        tick();
        push_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (count !== 5'd17) begin n_fail++; $display("FAIL fill_hold got cnt=%0d want 17", count); end
`ifdef FIFO_CTRL_ERR_EN
        n_tests++; if (ovf_err !== 1'b1) begin n_fail++; $display("FAIL fill_ovf got %0b want 1", ovf_err); end
`endif
    endtask

    task automatic test_full_simul();
        logic [7:0] exp;
        tick();
        push_valid = 1'b1;
        push_data  = 8'h55;
        pop_ready  = 1'b1;
        @(negedge clk);
        n_tests++; if (push_ready !== 1'b0 || mem_r_en !== 1'b1) begin n_fail++; $display("FAIL simul_edge got rdy=%0b ren=%0b want 0 1", push_ready, mem_r_en); end
        tick();
        pop_ready = 1'b0;
        @(negedge clk);
        n_tests++; if (count !== 5'd16 || mem_w_en !== 1'b1) begin n_fail++; $display("FAIL simul_retry got cnt=%0d wen=%0b want 16 1", count, mem_w_en); end
        tick();
        push_valid = 1'b0;
        pop_ready  = 1'b1;
        @(negedge clk);
        n_tests++; if (count !== 5'd17) begin n_fail++; $display("FAIL simul_count got %0d want 17", count); end
        for (int j = 1; j <= 17; j++) begin
            exp = (j <= 16) ? 8'(j) : 8'h55;
            if (j > 1) @(negedge clk);
            n_tests++; if (pop_valid !== 1'b1 || pop_data !== exp) begin n_fail++; $display("FAIL simul_drain_%0d got pv=%0b d=%h want 1 %h", j, pop_valid, pop_data, exp); end
            tick();
        end
        pop_ready = 1'b0;
        @(negedge clk);
        n_tests++; if (pop_valid !== 1'b0 || count !== 5'd0) begin n_fail++; $display("FAIL simul_empty got pv=%0b cnt=%0d want 0 0", pop_valid, count); end
    endtask

    task automatic test_back_to_back();
        int k = 0;
        int w_prev = -1;
        int r_prev = -1;
        int w_wraps = 0;
        int r_wraps = 0;
        for (int c = 0; c < 44; c++) begin
            tick();
            push_valid = (c < 40);
            push_data  = 8'(8'h80 + c);
            pop_ready  = 1'b1;
            @(negedge clk);
            if (mem_w_en) begin
                if (w_prev == 15 && mem_w_addr == 4'd0) w_wraps++;
                w_prev = int'(mem_w_addr);
            end
            if (mem_r_en) begin
                if (r_prev == 15 && mem_r_addr == 4'd0) r_wraps++;
                r_prev = int'(mem_r_addr);
            end
            if (c >= 2 && c <= 40) begin
                n_tests++; if (count !== 5'd2) begin n_fail++; $display("FAIL stream_count_c%0d got %0d want 2", c, count); end
                n_tests++; if (pop_valid !== 1'b1) begin n_fail++; $display("FAIL stream_gap_c%0d got pv=%0b want 1", c, pop_valid); end
            end
            if (pop_valid) begin
                n_tests++; if (pop_data !== 8'(8'h80 + k)) begin n_fail++; $display("FAIL stream_data_%0d got %h want %h", k, pop_data, 8'(8'h80 + k)); end
                k++;
            end
        end
        pop_ready = 1'b0;
        push_valid = 1'b0;
        n_tests++; if (k !== 40) begin n_fail++; $display("FAIL stream_total got %0d want 40", k); end
        n_tests++; if (w_wraps !== 2 || r_wraps !== 2) begin n_fail++; $display("FAIL stream_wraps got w=%0d r=%0d want 2 2", w_wraps, r_wraps); end
    endtask

    task automatic test_underflow();
        tick();
        pop_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_tests++; if (mem_r_en !== 1'b0 || pop_valid !== 1'b0) begin n_fail++; $display("FAIL udf_idle_%0d got ren=%0b pv=%0b want 0 0", c, mem_r_en, pop_valid); end
            tick();
        end
        pop_ready = 1'b0;
        tick();
        tick();
`ifdef FIFO_CTRL_ERR_EN
        @(negedge clk);
        n_tests++; if (udf_err !== 1'b1) begin n_fail++; $display("FAIL udf_sticky got %0b want 1", udf_err); end
`endif
    endtask

    task automatic test_midreset();
        for (int i = 0; i < 9; i++) begin
            tick();
            push_valid = 1'b1;
            push_data  = 8'(8'hE0 + i);
        end
        tick();
        push_valid = 1'b1;
        push_data  = 8'h77;
        pop_ready  = 1'b1;
        @(negedge clk);
        n_tests++; if (count !== 5'd9 || mem_r_en !== 1'b1 || mem_w_en !== 1'b1) begin n_fail++; $display("FAIL mid_pre got cnt=%0d ren=%0b wen=%0b want 9 1 1", count, mem_r_en, mem_w_en); end
        #1 rst_n = 1'b0;
        #1;
        n_tests++; if (pop_valid !== 1'b0 || count !== 5'd0 || mem_w_en !== 1'b0 || mem_r_en !== 1'b0) begin n_fail++; $display("FAIL mid_async got pv=%0b cnt=%0d wen=%0b ren=%0b want 0 0 0 0", pop_valid, count, mem_w_en, mem_r_en); end
`ifdef FIFO_CTRL_ERR_EN
        n_tests++; if (ovf_err !== 1'b0 || udf_err !== 1'b0) begin n_fail++; $display("FAIL mid_err got %0b %0b want 0 0", ovf_err, udf_err); end
`endif
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        push_valid = 1'b1;
        push_data  = 8'h3C;
        tick();
        push_valid = 1'b0;
        tick();
        @(negedge clk);
        n_tests++; if (pop_valid !== 1'b1 || pop_data !== 8'h3C || count !== 5'd1) begin n_fail++; $display("FAIL mid_fresh got pv=%0b d=%h cnt=%0d want 1 3c 1", pop_valid, pop_data, count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_full_simul();
        test_back_to_back();
        test_underflow();
        test_midreset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
